// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared state encoding and sizing helpers for the sequential multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed for a counter that must be able to hold the value `width`
  function automatic int unsigned cntWidth(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/add_n.sv
// add_n: parametrised ripple-carry adder, the multi-bit form of the 1-bit carry adder.
module add_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCarry,
  output logic [WIDTH-1:0] oY,
  output logic             oCarry
);

  // Ripple the carry bit by bit through a block-local variable
  always_comb begin
    logic c;
    c  = iCarry;
    oY = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      oY[i] = iA[i] ^ iB[i] ^ c;
      c     = (iA[i] & iB[i]) | (c & (iA[i] ^ iB[i]));
    end
    oCarry = c;
  end

endmodule

// File: rtl/seq_mul.sv
// seq_mul: radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH in WIDTH RUN cycles.
// Optional build macro SEQ_MUL_SIGNED_EN selects two's complement operands and result.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oY
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = cntWidth(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [W2-1:0]      acc;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               sumCarry;
  logic [W2-1:0]      accNext;
  logic [WIDTH-1:0]   aLoad;
  logic [WIDTH-1:0]   bLoad;
  logic [W2-1:0]      result;

`ifdef SEQ_MUL_SIGNED_EN
  logic               signFlag;

  // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1)
  always_comb begin
    aLoad = iA[WIDTH-1] ? WIDTH'(-iA) : iA;
    bLoad = iB[WIDTH-1] ? WIDTH'(-iB) : iB;
  end

  // Re-apply the product sign when the result is written out
  always_comb begin
    result = signFlag ? W2'(-acc) : acc;
  end

  // Product sign is captured alongside the operands
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      signFlag <= 1'b0;
    end else if (iStart && (state != ST_RUN)) begin
      signFlag <= iA[WIDTH-1] ^ iB[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands and result pass straight through
  always_comb begin
    aLoad  = iA;
    bLoad  = iB;
    result = acc;
  end
`endif

  // Partial product: add the multiplicand into the high half only when the LSB is set
  always_comb begin
    addend = acc[0] ? mcand : '0;
  end

  add_n #(
    .WIDTH (WIDTH)
  ) uAdd (
    .iA     (acc[W2-1:WIDTH]),
    .iB     (addend),
    .iCarry (1'b0),
    .oY     (sum),
    .oCarry (sumCarry)
  );

  // {carry, acc_hi + addend, acc_lo} shifted right by one
  always_comb begin
    accNext = {sumCarry, sum, acc[WIDTH-1:1]};
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= ST_IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oY    <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (iStart) begin
            mcand <= aLoad;
            acc   <= {WIDTH'(0), bLoad};
            cnt   <= '0;
            oBusy <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt != CNT_W'(WIDTH)) begin
            acc <= accNext;
            cnt <= cnt + CNT_W'(1);
            // Busy covers the WIDTH shift-add cycles; the write-out cycle follows
            if (cnt == CNT_W'(WIDTH - 1)) begin
              oBusy <= 1'b0;
            end
          end else begin
            oY    <= result;
            oDone <= 1'b1;
            oBusy <= 1'b0;
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: self-checking bench for seq_mul (WIDTH 4 directed, WIDTH 8/16 random sweep).
module tb_seq_mul;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;

  logic        start4 = 1'b0, start8 = 1'b0, start16 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy4, busy8, busy16;
  logic        done4, done8, done16;
  logic [7:0]  y4;
  logic [15:0] y8;
  logic [31:0] y16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_mul #(.WIDTH(4)) dut4 (
    .iClock(clk), .iReset_n(rstN), .iStart(start4), .iA(a4), .iB(b4),
    .oBusy(busy4), .oDone(done4), .oY(y4)
  );
  seq_mul #(.WIDTH(8)) dut8 (
    .iClock(clk), .iReset_n(rstN), .iStart(start8), .iA(a8), .iB(b8),
    .oBusy(busy8), .oDone(done8), .oY(y8)
  );
  seq_mul #(.WIDTH(16)) dut16 (
    .iClock(clk), .iReset_n(rstN), .iStart(start16), .iA(a16), .iB(b16),
    .oBusy(busy16), .oDone(done16), .oY(y16)
  );

  // Reference product: plain arithmetic on the operand values, truncated to 2*w bits
  function automatic longint refMul(input longint a, input longint b, input int w);
    longint sa = a;
    longint sb = b;
`ifdef SEQ_MUL_SIGNED_EN
    if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
`endif
    return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // One WIDTH=4 multiply; lat counts edges from the accept edge to the oDone cycle
  task automatic runMul4(input logic [3:0] a, input logic [3:0] b, input bit atNeg,
                         input bit intrude, output logic [7:0] y, output int lat,
                         output int busyCyc, output int doneCnt);
    if (!atNeg) @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = -1; busyCyc = 0; doneCnt = 0; y = '0;
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      if (intrude && n == 1) begin start4 = 1'b1; a4 = 4'd15; b4 = 4'd15; end
      if (intrude && n == 2) start4 = 1'b0;
      if (busy4) busyCyc++;
      if (done4) begin
        doneCnt++;
        if (lat < 0) begin lat = n; y = y4; end
        if (!intrude) break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({busy4, done4, y4} !== 10'd0)
      begin fails++; $display("FAIL reset_w4: got busy=%b done=%b y=%h, want 0/0/00", busy4, done4, y4); end
    tests++;
    if ({busy8, done8, y8, busy16, done16, y16} !== 52'd0)
      begin fails++; $display("FAIL reset_w8_w16: got y8=%h y16=%h busy=%b%b done=%b%b, want zeros", y8, y16, busy8, busy16, done8, done16); end
    rstN = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] y; int lat, bc, dc;
    runMul4(4'd15, 4'd15, 1'b0, 1'b0, y, lat, bc, dc);
    tests++;
    if (y !== 8'(refMul(15, 15, 4)))
      begin fails++; $display("FAIL basic_y: got %h, want %h", y, 8'(refMul(15, 15, 4))); end
    tests++;
    if (lat != 5) begin fails++; $display("FAIL basic_latency: got %0d, want 5", lat); end
    tests++;
    if (bc != 4) begin fails++; $display("FAIL basic_busy_cycles: got %0d, want 4", bc); end
    @(negedge clk);
    tests++;
    if (done4 !== 1'b0 || busy4 !== 1'b0 || y4 !== y)
      begin fails++; $display("FAIL basic_pulse_hold: got done=%b busy=%b y=%h, want 0/0/%h", done4, busy4, y4, y); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] y; int lat, bc, dc;
    runMul4(4'd0, 4'd9, 1'b0, 1'b0, y, lat, bc, dc);
    tests++;
    if (y !== 8'd0 || lat != 5)
      begin fails++; $display("FAIL zero_operand: got y=%h lat=%0d, want 00 lat 5", y, lat); end
    runMul4(4'd6, 4'd7, 1'b1, 1'b0, y, lat, bc, dc);
    tests++;
    if (y !== 8'(refMul(6, 7, 4)) || lat != 5)
      begin fails++; $display("FAIL back_to_back: got y=%h lat=%0d, want %h lat 5", y, lat, 8'(refMul(6, 7, 4))); end
  endtask

  task automatic test_ignore_start();
    logic [7:0] y; int lat, bc, dc;
    @(negedge clk);
    runMul4(4'd3, 4'd5, 1'b0, 1'b1, y, lat, bc, dc);
    tests++;
    if (y !== 8'(refMul(3, 5, 4)) || lat != 5)
      begin fails++; $display("FAIL ignore_start_y: got y=%h lat=%0d, want %h lat 5", y, lat, 8'(refMul(3, 5, 4))); end
    tests++;
    if (dc != 1) begin fails++; $display("FAIL ignore_start_done_count: got %0d, want 1", dc); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] y; int lat, bc, dc; int badDone;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd11;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    tests++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || y4 !== 8'd0)
      begin fails++; $display("FAIL abort_reset: got busy=%b done=%b y=%h, want 0/0/00", busy4, done4, y4); end
    badDone = 0;
    repeat (3) begin @(negedge clk); if (done4 !== 1'b0) badDone++; end
    rstN = 1'b1;
    repeat (6) begin @(negedge clk); if (done4 !== 1'b0) badDone++; end
    tests++;
    if (badDone != 0) begin fails++; $display("FAIL abort_no_done: got %0d done cycles, want 0", badDone); end
    runMul4(4'd12, 4'd11, 1'b0, 1'b0, y, lat, bc, dc);
    tests++;
    if (y !== 8'(refMul(12, 11, 4)) || lat != 5)
      begin fails++; $display("FAIL after_abort: got y=%h lat=%0d, want %h lat 5", y, lat, 8'(refMul(12, 11, 4))); end
  endtask

`ifdef SEQ_MUL_SIGNED_EN
  task automatic test_signed();
    logic [7:0] y; int lat, bc, dc;
    runMul4(4'b1000, 4'b1000, 1'b0, 1'b0, y, lat, bc, dc);
    tests++;
    if (y !== 8'h40) begin fails++; $display("FAIL signed_m8_m8: got %h, want 40", y); end
    runMul4(4'b1000, 4'd7, 1'b0, 1'b0, y, lat, bc, dc);
    tests++;
    if (y !== 8'hC8) begin fails++; $display("FAIL signed_m8_7: got %h, want c8", y); end
    runMul4(4'd3, 4'b1111, 1'b0, 1'b0, y, lat, bc, dc);
    tests++;
    if (y !== 8'hFD || lat != 5) begin fails++; $display("FAIL signed_3_m1: got %h lat=%0d, want fd lat 5", y, lat); end
  endtask
`endif

  task automatic test_random8();
    logic [7:0] a, b; logic [15:0] exp; int lat, bc;
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (k == 0) a = 8'h00;
      if (k == 1) begin a = 8'hFF; b = 8'hFF; end
      if (k == 2) begin a = 8'h80; b = 8'h80; end
      exp = 16'(refMul(longint'(a), longint'(b), 8));
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = -1; bc = 0;
      for (int n = 0; n <= 12; n++) begin
        @(negedge clk);
        if (busy8) bc++;
        if (done8) begin lat = n; break; end
      end
      tests++;
      if (lat != 9 || y8 !== exp)
        begin fails++; $display("FAIL rand8 %h*%h: got y=%h lat=%0d, want %h lat 9", a, b, y8, lat, exp); end
      tests++;
      if (bc != 8) begin fails++; $display("FAIL rand8_busy: got %0d busy cycles, want 8", bc); end
      @(negedge clk);
      tests++;
      if (done8 !== 1'b0 || busy8 !== 1'b0)
        begin fails++; $display("FAIL rand8_idle: got done=%b busy=%b, want 0/0", done8, busy8); end
    end
  endtask

  task automatic test_random16();
    logic [15:0] a, b; logic [31:0] exp; int lat, bc;
    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (k == 0) b = 16'h0000;
      if (k == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
      if (k == 2) begin a = 16'h8000; b = 16'h7FFF; end
      exp = 32'(refMul(longint'(a), longint'(b), 16));
      @(negedge clk);
      start16 = 1'b1; a16 = a; b16 = b;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      lat = -1; bc = 0;
      for (int n = 0; n <= 20; n++) begin
        @(negedge clk);
        if (busy16) bc++;
        if (done16) begin lat = n; break; end
      end
      tests++;
      if (lat != 17 || y16 !== exp)
        begin fails++; $display("FAIL rand16 %h*%h: got y=%h lat=%0d, want %h lat 17", a, b, y16, lat, exp); end
      tests++;
      if (bc != 16) begin fails++; $display("FAIL rand16_busy: got %0d busy cycles, want 16", bc); end
      @(negedge clk);
      tests++;
      if (done16 !== 1'b0 || busy16 !== 1'b0)
        begin fails++; $display("FAIL rand16_idle: got done=%b busy=%b, want 0/0", done16, busy16); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
`ifdef SEQ_MUL_SIGNED_EN
    test_signed();
`endif
    test_random8();
    test_random16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
